// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the MIPS-subset CPU with retired-instruction counter
module mc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        memReady,
    output logic [3:0]  state,
    output logic        pcWe,
    output logic        irWe,
    output logic        regWe,
    output logic        memWe,
    output logic        memRe,
    output logic        iOrD,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic        immZext,
    output logic [1:0]  aluOp,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic [1:0]  pcSrc,
    output logic        retire,
    output logic        illegal,
    output logic [31:0] instrCount
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
        MEM_WR = 4'd5, EXEC_R = 4'd6, WB_R = 4'd7, EXEC_I = 4'd8, WB_I = 4'd9,
        BRANCH = 4'd10, JUMP = 4'd11, JAL = 4'd12, JR = 4'd13, TRAP = 4'd15
    } st_t;

    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, XOR = 2'd2, SLT = 2'd3;

    st_t  st;
    logic pc_we, ir_we, reg_we, mem_we, mem_re, ret;
    logic xori;

    assign xori  = opcode == 6'h0e;
    assign state = st;

    // Enables and retire are suppressed while reset is held; selects keep their FETCH values.
    assign pcWe   = pc_we & ~reset;
    assign irWe   = ir_we & ~reset;
    assign regWe  = reg_we & ~reset;
    assign memWe  = mem_we & ~reset;
    assign memRe  = mem_re & ~reset;
    assign retire = ret & ~reset;

    function automatic st_t dispatch(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:        return (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a) ? EXEC_R :
                                 fn == 6'h08 ? JR : TRAP;
            6'h23, 6'h2b: return MEM_ADDR;
            6'h02:        return JUMP;
            6'h03:        return JAL;
            6'h04, 6'h05: return BRANCH;
            6'h08, 6'h0e: return EXEC_I;
            default:      return TRAP;
        endcase
    endfunction

    // State register and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= FETCH;
            instrCount <= 32'd0;
        end else begin
            instrCount <= instrCount + {31'd0, ret};
            case (st)
                FETCH:    if (memReady) st <= DECODE;
                DECODE:   st <= dispatch(opcode, funct);
                MEM_ADDR: st <= opcode == 6'h23 ? MEM_RD : MEM_WR;
                MEM_RD:   if (memReady) st <= MEM_WB;
                MEM_WR:   if (memReady) st <= FETCH;
                EXEC_R:   st <= WB_R;
                EXEC_I:   st <= WB_I;
                TRAP:     st <= TRAP;
                default:  st <= FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the current state (plus memReady, zero, opcode/funct).
    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        ret      = 1'b0;
        iOrD     = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'd0;
        immZext  = 1'b0;
        aluOp    = ADD;
        regDst   = 2'd0;
        memToReg = 2'd0;
        pcSrc    = 2'd0;
        illegal  = 1'b0;
        case (st)
            FETCH:    begin mem_re = 1'b1; aluSrcB = 2'd1; ir_we = memReady; pc_we = memReady; end
            DECODE:   aluSrcB = 2'd3;
            MEM_ADDR: begin aluSrcA = 1'b1; aluSrcB = 2'd2; end
            MEM_RD:   begin mem_re = 1'b1; iOrD = 1'b1; end
            MEM_WB:   begin reg_we = 1'b1; memToReg = 2'd1; ret = 1'b1; end
            MEM_WR:   begin mem_we = 1'b1; iOrD = 1'b1; ret = memReady; end
            EXEC_R:   begin aluSrcA = 1'b1; aluOp = funct == 6'h22 ? SUB : funct == 6'h2a ? SLT : ADD; end
            WB_R:     begin reg_we = 1'b1; regDst = 2'd1; ret = 1'b1; end
            EXEC_I:   begin aluSrcA = 1'b1; aluSrcB = 2'd2; immZext = xori; aluOp = xori ? XOR : ADD; end
            WB_I:     begin reg_we = 1'b1; immZext = xori; ret = 1'b1; end
            BRANCH:   begin aluSrcA = 1'b1; aluOp = SUB; pcSrc = 2'd1; pc_we = opcode == 6'h05 ? ~zero : zero; ret = 1'b1; end
            JUMP:     begin pc_we = 1'b1; pcSrc = 2'd2; ret = 1'b1; end
            JAL:      begin pc_we = 1'b1; pcSrc = 2'd2; reg_we = 1'b1; regDst = 2'd2; memToReg = 2'd2; ret = 1'b1; end
            JR:       begin pc_we = 1'b1; pcSrc = 2'd3; ret = 1'b1; end
            TRAP:     illegal = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the MIPS-subset CPU. It sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback. From the IR opcode/funct, the ALU zero flag and a memory-ready handshake it produces every datapath select and write enable. It also maintains a retired-instruction counter for benches.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state FETCH, clears instrCount
- opcode  in  6  IR[31:26], stable from DECODE until next FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- memReady  in  1  memory completes current access this cycle
- state  out  4  current state (debug)
- pcWe, irWe, regWe, memWe  out  1 each  write enables
- memRe  out  1  memory read request
- iOrD  out  1  memory address select: 0=PC, 1=ALUOut
- aluSrcA  out  1  0=PC, 1=regA
- aluSrcB  out  2  0=regB, 1=const 4, 2=extended imm, 3=sign-ext imm<<2
- immZext  out  1  1 selects zero-extension for aluSrcB=2 (XORI only)
- aluOp  out  2  0=ADD, 1=SUB, 2=XOR, 3=SLT
- regDst  out  2  0=rt, 1=rd, 2=r31
- memToReg  out  2  0=ALUOut, 1=MDR, 2=PC
- pcSrc  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}, 3=regA
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  high while in TRAP
- instrCount  out  32  retired instructions

## Operation
- Supported instructions: R-type (opcode 0x00) ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08; LW 0x23, SW 0x2b, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0e.
- Any other opcode or funct goes to TRAP.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, WB_R 7, EXEC_I 8, WB_I 9, BRANCH 10, JUMP 11, JAL 12, JR 13, TRAP 15.
- Unlisted outputs are 0 in each state.
- FETCH: memRe=1, iOrD=0, aluSrcA=0, aluSrcB=1, aluOp=ADD, pcSrc=0.
  - irWe=pcWe=memReady.
  - Go to DECODE on memReady; otherwise hold.
- DECODE: aluSrcA=0, aluSrcB=3, aluOp=ADD (branch target into ALUOut). Dispatch on opcode/funct.
- MEM_ADDR: aluSrcA=1, aluSrcB=2, aluOp=ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: memRe=1, iOrD=1. Hold until memReady, then go to MEM_WB.
- MEM_WB: regWe=1, regDst=0, memToReg=1. Retire.
- MEM_WR: memWe=1, iOrD=1. Hold until memReady; retire on the cycle memReady is high.
- EXEC_R: aluSrcA=1, aluSrcB=0, aluOp from funct (ADD/SUB/SLT).
- WB_R: regWe=1, regDst=1, memToReg=0. Retire.
- EXEC_I: aluSrcA=1, aluSrcB=2, aluOp ADD for ADDI, XOR with immZext=1 for XORI.
- WB_I: regWe=1, regDst=0, memToReg=0. Retire.
  - immZext stays 1 through WB_I for XORI.
- BRANCH: aluSrcA=1, aluSrcB=0, aluOp=SUB, pcSrc=1.
  - pcWe = zero for BEQ, ~zero for BNE.
  - Retire.
- JUMP: pcWe=1, pcSrc=2. Retire.
- JAL: pcWe=1, pcSrc=2, regWe=1, regDst=2, memToReg=2.
  - The write captures the PC value before the edge, i.e. PC+4 from FETCH.
  - Retire.
- JR: pcWe=1, pcSrc=3. Retire.
- Every retiring state goes to FETCH; instrCount increments by 1 on that edge and wraps at 2^32-1 -> 0.
- TRAP: illegal=1, every enable 0, no retire. TRAP is absorbing; only reset exits.

## Timing
- Next state is registered. Outputs are combinational from state, plus memReady, zero and opcode/funct where noted above.
- While reset is high: state=FETCH, instrCount=0, and pcWe/irWe/regWe/memWe/memRe/retire are forced 0. All other outputs take their FETCH values.
- Reset mid-instruction aborts the instruction with no further writes; fetch restarts on the first edge after deassertion.
- Cycles per instruction with memReady tied high: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J/JAL/JR 3.
- Each memReady-low cycle in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle; no enable pulses during the wait.
- memReady is ignored outside FETCH, MEM_RD and MEM_WR.

## Test plan
- ADDI then ADD, memReady=1:
  - state sequence 0,1,8,9,0,1,6,7,0
  - regWe high only in states 9 and 7
  - instrCount=2 after 8 cycles
- LW with memReady low for 2 cycles in MEM_RD:
  - state sequence 0,1,2,3,3,3,4,0 (7 cycles after FETCH)
  - memToReg=1 and regDst=0 in state 4
- BEQ with zero=1 and with zero=0, then BNE with the same two cases:
  - pcWe=1 in BRANCH only for (BEQ, zero=1) and (BNE, zero=0)
  - pcSrc=1 in all four cases
- JAL:
  - one cycle in state 12 with regDst=2, memToReg=2, pcSrc=2, regWe=pcWe=1
- Opcode 0x3f:
  - DECODE -> TRAP; illegal=1, all enables 0 for 10 cycles, instrCount unchanged
  - reset pulse returns to FETCH with instrCount=0
- Reset asserted asynchronously in MEM_WR with memReady=0:
  - memWe drops immediately
  - state=0 and instrCount=0 without waiting for a clock edge
